gci_std_display_vram_arbiter: RTL and testbench
===============================================

# gci_std_display_vram_arbiter

Arbitrates one VRAM memory port between two requesters that use the display REQ/ACK/FINISH ownership handshake, such as the scanout reader and the drawing/write path. The owner's access signals are multiplexed onto the memory port, and read data is routed back to the owner. Ownership is not handed over while any read is still outstanding. The block sits between the display controller interfaces and the VRAM (SRAM/SDRAM) controller.

## Interface
- P_MEM_ADDR_N, 19, VRAM word-address width
- P_OUTSTD_N, 4, outstanding-read counter width; maximum outstanding = 2^P_OUTSTD_N-1
- P_TIMEOUT_N, 10, watchdog counter width (used only with the macro)
- iCLOCK  in  1  sole clock, rising edge
- iRESET_SYNC  in  1  synchronous reset, active-high
- iIFx_REQ  in  1  ownership request, x∈{0,1}, level, held until ACK
- oIFx_ACK  out  1  one-cycle grant pulse
- iIFx_FINISH  in  1  one-cycle ownership release
- iIFx_ENA  in  1  access strobe, valid only while owner
- oIFx_BUSY  out  1  access stall; 1 whenever IFx is not the owner
- iIFx_RW  in  1  1=write, 0=read
- iIFx_ADDR  in  P_MEM_ADDR_N  access address
- iIFx_DATA  in  32  write data
- oIFx_VALID  out  1  read-data strobe
- oIFx_DATA  out  32  read data
- oMEM_ENA / oMEM_RW / oMEM_ADDR / oMEM_DATA  out  1/1/P_MEM_ADDR_N/32  memory access port
- iMEM_BUSY  in  1  memory stall; an access is accepted when ENA&&!BUSY
- iMEM_VALID / iMEM_DATA  in  1/32  in-order read return
- oTIMEOUT  out  1  one-cycle watchdog-fired pulse

## Operation
- States: IDLE, GRANT0, GRANT1, DRAIN. Register b_owner (0/1) holds the last or current owner.
- IDLE:
  - One request → GRANTx, with oIFx_ACK pulsed in the next cycle.
  - Both requests → grant the IF that is not b_owner (round-robin). After reset, b_owner=1, so IF0 wins the first tie.
- GRANTx:
  - oMEM_* = iIFx_* combinationally, with oMEM_ENA = iIFx_ENA && !outstd_full.
  - oIFx_BUSY = iMEM_BUSY || outstd_full.
- Outstanding counter:
  - +1 on an accepted read; −1 on iMEM_VALID; both in one cycle → unchanged.
  - outstd_full = (count == max).
- Release on iIFx_FINISH:
  - If the next count (after this cycle's accept/return) is 0 → IDLE.
  - Otherwise → DRAIN.
  - An ENA accepted in the FINISH cycle is performed.
- DRAIN:
  - oMEM_ENA=0 and both BUSY=1; wait until count==0, then IDLE.
- Read return: iMEM_VALID/iMEM_DATA are routed to b_owner in GRANT and DRAIN. In IDLE they are discarded.
- A REQ from the current owner during GRANT is ignored. REQ must not be asserted in the same cycle as FINISH.
- Count underflow (VALID at count 0) saturates at 0 and the VALID is discarded.

## Timing
- Reset values: state IDLE, count 0, b_owner=1, all ACK/VALID/oMEM_ENA/oTIMEOUT=0, both oIFx_BUSY=1, data outputs 0.
- REQ sampled in cycle N (IDLE) → ACK and ownership at N+1. The owner may drive ENA from N+1.
- FINISH at N → IDLE at N+1 (no reads pending); the earliest next ACK is at N+2.
- Mux and BUSY paths are combinational, so they add zero cycles. oIFx_VALID/DATA are combinational from iMEM_*.
- iRESET_SYNC mid-operation: return to IDLE next cycle and clear count. Late returns are discarded.

## Configuration
- GCI_STD_DISPLAY_VRAM_ARB_TIMEOUT_EN defined:
  - A P_TIMEOUT_N-bit counter runs in GRANTx and clears on each accepted ENA or on grant.
  - When it reaches all-ones, the owner is treated as if FINISH were asserted (→IDLE or DRAIN) and oTIMEOUT pulses once.
- Not defined: no watchdog counter; oTIMEOUT tied 0; ownership lasts until FINISH.

## Structure
- Shared package gci_std_display_pkg: state encodings (P_L_ARB_IDLE=2'h0, GRANT0=2'h1, GRANT1=2'h2, DRAIN=2'h3) and the default widths.
- Sub-module gci_std_display_vram_arb_outstd: up/down counter with full/zero flags and underflow saturation, parameterised by P_OUTSTD_N.

## Test plan
- IF0 REQ alone → ACK0 at +1. Two writes to 0x00010/0x00011 data 0xA5A5_0001/2 appear on oMEM. FINISH → IDLE at +1, with oIF1_BUSY=1 throughout.
- IF0 and IF1 REQ in the same cycle after reset → IF0 granted. Repeating after FINISH → IF1 granted (round-robin).
- IF1 issues 3 reads, then FINISH; memory returns VALID 5 cycles later → state DRAIN, 3 VALIDs on oIF1 only, then IDLE. A pending IF0 REQ is ACKed only afterwards.
- 15 reads with iMEM_VALID held 0 (P_OUTSTD_N=4) → 16th ENA blocked with oIF0_BUSY=1. One VALID → 16th accepted.
- iRESET_SYNC pulsed with 2 reads outstanding → IDLE and count 0. A subsequent iMEM_VALID gives no oIFx_VALID.
- Macro on, P_TIMEOUT_N=4: owner holds for 15 idle cycles → oTIMEOUT pulse and IDLE. Macro off → still owner after 100 cycles.

Source files
------------

// File: rtl/gci_std_display_pkg.sv
// ---------------------------------------------------------------------------
// gci_std_display_pkg
//
// Shared definitions for the display VRAM path:
//   - arb_state_t : arbiter state encoding (IDLE / GRANT0 / GRANT1 / DRAIN)
//   - P_L_*       : default VRAM address, outstanding-read and watchdog widths
//   - arb_is_grant: true while one of the two requesters owns the memory port
// ---------------------------------------------------------------------------
package gci_std_display_pkg;

    typedef enum logic [1:0] {
        P_L_ARB_IDLE   = 2'h0,
        P_L_ARB_GRANT0 = 2'h1,
        P_L_ARB_GRANT1 = 2'h2,
        P_L_ARB_DRAIN  = 2'h3
    } arb_state_t;

    localparam int P_L_MEM_ADDR_N = 19;
    localparam int P_L_OUTSTD_N   = 4;
    localparam int P_L_TIMEOUT_N  = 10;

    function automatic logic arb_is_grant(input arb_state_t state);
        return (state == P_L_ARB_GRANT0) || (state == P_L_ARB_GRANT1);
    endfunction

endpackage

// File: rtl/gci_std_display_vram_arb_outstd.sv
// ---------------------------------------------------------------------------
// gci_std_display_vram_arb_outstd
//
// Outstanding-read tracker for the VRAM arbiter. Counts reads accepted by the
// memory that have not yet returned data.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset, clears the count
//   inc        in   a read was accepted by the memory this cycle
//   dec        in   a read return arrived this cycle
//   full       out  count is at its maximum (2^P_OUTSTD_N-1)
//   zero       out  no reads outstanding
//   next_zero  out  count will be zero after this cycle's inc/dec
// ---------------------------------------------------------------------------
module gci_std_display_vram_arb_outstd
    import gci_std_display_pkg::*;
#(
    parameter int P_OUTSTD_N = P_L_OUTSTD_N
)(
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic zero,
    output logic next_zero
);

    logic [P_OUTSTD_N-1:0] count;
    logic [P_OUTSTD_N-1:0] next_count;
    logic                  inc_ok;
    logic                  dec_ok;

    // A return with nothing outstanding is a stray and must not wrap the
    // counter; an increment past full cannot be tracked and is refused.
    // Simultaneous accept and return cancel out.
    always_comb begin
        inc_ok     = inc && !full;
        dec_ok     = dec && !zero;
        next_count = count;
        case ({inc_ok, dec_ok})
            2'b10:   next_count = count + 1'b1;
            2'b01:   next_count = count - 1'b1;
            default: next_count = count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= next_count;
        end
    end

    assign full      = (count == '1);
    assign zero      = (count == '0);
    assign next_zero = (next_count == '0);

endmodule

// File: rtl/gci_std_display_vram_arbiter.sv
// ---------------------------------------------------------------------------
// gci_std_display_vram_arbiter
//
// Shares one VRAM memory port between two requesters (e.g. scanout reader and
// drawing path) using the REQ / ACK / FINISH ownership handshake. The owner's
// access strobes are muxed onto the memory port and read data is routed back
// to the owner. Ownership is never handed over while reads are outstanding:
// a release with reads in flight parks the arbiter in DRAIN until they return.
//
// Optional feature (macro GCI_STD_DISPLAY_VRAM_ARB_TIMEOUT_EN):
//   watchdog that revokes ownership after 2^P_TIMEOUT_N-1 cycles without an
//   accepted access and pulses oTIMEOUT. Without the macro oTIMEOUT is 0.
//
// Ports:
//   iCLOCK, iRESET_SYNC            clock, synchronous active-high reset
//   iIFx_REQ / oIFx_ACK            ownership request (level) / grant pulse
//   iIFx_FINISH                    one-cycle ownership release
//   iIFx_ENA/RW/ADDR/DATA          owner access (RW 1 = write)
//   oIFx_BUSY                      stall; always 1 for a non-owner
//   oIFx_VALID / oIFx_DATA         read return routed to the owner
//   oMEM_ENA/RW/ADDR/DATA          memory access port
//   iMEM_BUSY                      memory stall
//   iMEM_VALID / iMEM_DATA         in-order read return from memory
//   oTIMEOUT                       one-cycle watchdog pulse
// ---------------------------------------------------------------------------
module gci_std_display_vram_arbiter
    import gci_std_display_pkg::*;
#(
    parameter int P_MEM_ADDR_N = P_L_MEM_ADDR_N,
    parameter int P_OUTSTD_N   = P_L_OUTSTD_N,
    parameter int P_TIMEOUT_N  = P_L_TIMEOUT_N
)(
    input  logic                    iCLOCK,
    input  logic                    iRESET_SYNC,
    input  logic                    iIF0_REQ,
    output logic                    oIF0_ACK,
    input  logic                    iIF0_FINISH,
    input  logic                    iIF0_ENA,
    output logic                    oIF0_BUSY,
    input  logic                    iIF0_RW,
    input  logic [P_MEM_ADDR_N-1:0] iIF0_ADDR,
    input  logic [31:0]             iIF0_DATA,
    output logic                    oIF0_VALID,
    output logic [31:0]             oIF0_DATA,
    input  logic                    iIF1_REQ,
    output logic                    oIF1_ACK,
    input  logic                    iIF1_FINISH,
    input  logic                    iIF1_ENA,
    output logic                    oIF1_BUSY,
    input  logic                    iIF1_RW,
    input  logic [P_MEM_ADDR_N-1:0] iIF1_ADDR,
    input  logic [31:0]             iIF1_DATA,
    output logic                    oIF1_VALID,
    output logic [31:0]             oIF1_DATA,
    output logic                    oMEM_ENA,
    output logic                    oMEM_RW,
    output logic [P_MEM_ADDR_N-1:0] oMEM_ADDR,
    output logic [31:0]             oMEM_DATA,
    input  logic                    iMEM_BUSY,
    input  logic                    iMEM_VALID,
    input  logic [31:0]             iMEM_DATA,
    output logic                    oTIMEOUT
);

    arb_state_t              state;
    logic                    b_owner;
    logic                    ack0;
    logic                    ack1;

    logic                    in_grant;
    logic                    own_ena;
    logic                    own_rw;
    logic                    own_finish;
    logic [P_MEM_ADDR_N-1:0] own_addr;
    logic [31:0]             own_data;
    logic                    mem_ena;
    logic                    accept;
    logic                    rd_accept;
    logic                    route;
    logic                    release_own;
    logic                    wd_fire;

    logic                    outstd_full;
    logic                    outstd_zero;
    logic                    outstd_next_zero;

    // Owner selection. Outside GRANT nothing reaches the memory port, so the
    // muxed fields fall back to zero rather than leaking a requester's bus.
    always_comb begin
        own_ena    = 1'b0;
        own_rw     = 1'b0;
        own_finish = 1'b0;
        own_addr   = '0;
        own_data   = '0;
        case (state)
            P_L_ARB_GRANT0: begin
                own_ena    = iIF0_ENA;
                own_rw     = iIF0_RW;
                own_finish = iIF0_FINISH;
                own_addr   = iIF0_ADDR;
                own_data   = iIF0_DATA;
            end
            P_L_ARB_GRANT1: begin
                own_ena    = iIF1_ENA;
                own_rw     = iIF1_RW;
                own_finish = iIF1_FINISH;
                own_addr   = iIF1_ADDR;
                own_data   = iIF1_DATA;
            end
            default: begin
                own_ena    = 1'b0;
                own_rw     = 1'b0;
                own_finish = 1'b0;
                own_addr   = '0;
                own_data   = '0;
            end
        endcase
    end

    // Access acceptance and read-return routing. A full tracker blocks new
    // accesses of either kind so that read ordering stays simple. Returns
    // are only forwarded while something is actually outstanding; a stray
    // return (including one arriving after a reset) is dropped.
    always_comb begin
        in_grant    = arb_is_grant(state);
        mem_ena     = in_grant && own_ena && !outstd_full;
        accept      = mem_ena && !iMEM_BUSY;
        rd_accept   = accept && !own_rw;
        route       = (state != P_L_ARB_IDLE) && iMEM_VALID && !outstd_zero;
        release_own = in_grant && (own_finish || wd_fire);
    end

    gci_std_display_vram_arb_outstd #(
        .P_OUTSTD_N (P_OUTSTD_N)
    ) u_outstd (
        .clock     (iCLOCK),
        .reset     (iRESET_SYNC),
        .inc       (rd_accept),
        .dec       (iMEM_VALID),
        .full      (outstd_full),
        .zero      (outstd_zero),
        .next_zero (outstd_next_zero)
    );

`ifdef GCI_STD_DISPLAY_VRAM_ARB_TIMEOUT_EN
    logic [P_TIMEOUT_N-1:0] wd_count;
    logic                   timeout_q;

    assign wd_fire  = in_grant && (wd_count == '1);
    assign oTIMEOUT = timeout_q;

    // Watchdog counts idle ownership cycles; any accepted access restarts
    // it and leaving GRANT (including on the fire itself) clears it, so a
    // fresh grant always starts from zero.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC || !in_grant || accept) begin
            wd_count <= '0;
        end else if (!wd_fire) begin
            wd_count <= wd_count + 1'b1;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_fire;
        end
    end
`else
    // Watchdog compiled out: ownership lasts until FINISH and oTIMEOUT stays
    // low. P_TIMEOUT_N is referenced only so both builds share one
    // parameter list.
    assign wd_fire  = 1'b0;
    assign oTIMEOUT = 1'b0 & (P_TIMEOUT_N > 0);
`endif

    // Ownership FSM. Ties in IDLE go to the requester that did not own the
    // port last (b_owner resets to 1 so IF0 wins the first tie). A release
    // with reads still in flight waits in DRAIN; the next-count look-ahead
    // lets a release whose last return lands in the same cycle go straight
    // to IDLE.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state   <= P_L_ARB_IDLE;
            b_owner <= 1'b1;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                P_L_ARB_IDLE: begin
                    if (iIF0_REQ && (!iIF1_REQ || b_owner)) begin
                        state   <= P_L_ARB_GRANT0;
                        b_owner <= 1'b0;
                        ack0    <= 1'b1;
                    end else if (iIF1_REQ) begin
                        state   <= P_L_ARB_GRANT1;
                        b_owner <= 1'b1;
                        ack1    <= 1'b1;
                    end
                end
                P_L_ARB_GRANT0, P_L_ARB_GRANT1: begin
                    if (release_own) begin
                        state <= outstd_next_zero ? P_L_ARB_IDLE : P_L_ARB_DRAIN;
                    end
                end
                P_L_ARB_DRAIN: begin
                    if (outstd_next_zero) begin
                        state <= P_L_ARB_IDLE;
                    end
                end
                default: state <= P_L_ARB_IDLE;
            endcase
        end
    end

    assign oIF0_ACK   = ack0;
    assign oIF1_ACK   = ack1;

    assign oMEM_ENA   = mem_ena;
    assign oMEM_RW    = own_rw;
    assign oMEM_ADDR  = own_addr;
    assign oMEM_DATA  = own_data;

    assign oIF0_BUSY  = (state != P_L_ARB_GRANT0) || iMEM_BUSY || outstd_full;
    assign oIF1_BUSY  = (state != P_L_ARB_GRANT1) || iMEM_BUSY || outstd_full;

    assign oIF0_VALID = route && !b_owner;
    assign oIF1_VALID = route && b_owner;
    assign oIF0_DATA  = oIF0_VALID ? iMEM_DATA : 32'h0;
    assign oIF1_DATA  = oIF1_VALID ? iMEM_DATA : 32'h0;

endmodule

// File: tb/tb_gci_std_display_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gci_std_display_vram_arbiter
//
// Scoreboarded bench for the VRAM arbiter. Accesses expected on the memory
// port and read returns expected on an IF are queued when driven and popped
// by a negedge monitor when the DUT shows them. Directed checks cover reset,
// grant timing, round-robin, drain, full tracker, reset mid-read and the
// watchdog (macro GCI_STD_DISPLAY_VRAM_ARB_TIMEOUT_EN, P_TIMEOUT_N=4).
// ---------------------------------------------------------------------------
module tb_gci_std_display_vram_arbiter;

   typedef struct packed {
      logic        rw;
      logic [18:0] addr;
      logic [31:0] data;
   } memTxn_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        if0Req = 1'b0, if0Finish = 1'b0, if0Ena = 1'b0, if0Rw = 1'b0;
   logic [18:0] if0Addr = '0;
   logic [31:0] if0DataIn = '0;
   logic        if0Ack, if0Busy, if0Valid;
   logic [31:0] if0DataOut;
   logic        if1Req = 1'b0, if1Finish = 1'b0, if1Ena = 1'b0, if1Rw = 1'b0;
   logic [18:0] if1Addr = '0;
   logic [31:0] if1DataIn = '0;
   logic        if1Ack, if1Busy, if1Valid;
   logic [31:0] if1DataOut;
   logic        memEna, memRw;
   logic [18:0] memAddr;
   logic [31:0] memDataOut;
   logic        memBusy = 1'b0, memValid = 1'b0;
   logic [31:0] memDataIn = '0;
   logic        timeoutPulse;

   int          vectors = 0;
   int          miscompares = 0;
   memTxn_t     memQ[$];
   logic [32:0] retQ[$];

   gci_std_display_vram_arbiter #(
      .P_MEM_ADDR_N (19),
      .P_OUTSTD_N   (4),
      .P_TIMEOUT_N  (4)
   ) dut (
      .iCLOCK      (clock),
      .iRESET_SYNC (reset),
      .iIF0_REQ    (if0Req),
      .oIF0_ACK    (if0Ack),
      .iIF0_FINISH (if0Finish),
      .iIF0_ENA    (if0Ena),
      .oIF0_BUSY   (if0Busy),
      .iIF0_RW     (if0Rw),
      .iIF0_ADDR   (if0Addr),
      .iIF0_DATA   (if0DataIn),
      .oIF0_VALID  (if0Valid),
      .oIF0_DATA   (if0DataOut),
      .iIF1_REQ    (if1Req),
      .oIF1_ACK    (if1Ack),
      .iIF1_FINISH (if1Finish),
      .iIF1_ENA    (if1Ena),
      .oIF1_BUSY   (if1Busy),
      .iIF1_RW     (if1Rw),
      .iIF1_ADDR   (if1Addr),
      .iIF1_DATA   (if1DataIn),
      .oIF1_VALID  (if1Valid),
      .oIF1_DATA   (if1DataOut),
      .oMEM_ENA    (memEna),
      .oMEM_RW     (memRw),
      .oMEM_ADDR   (memAddr),
      .oMEM_DATA   (memDataOut),
      .iMEM_BUSY   (memBusy),
      .iMEM_VALID  (memValid),
      .iMEM_DATA   (memDataIn),
      .oTIMEOUT    (timeoutPulse)
   );

   // 10-unit clock period
   always #5 clock = ~clock;

   // Every comparison in the bench is funnelled through here
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Inputs change 1 unit after the rising edge
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Outputs are observed on the falling edge
   task automatic sample();
      @(negedge clock);
   endtask

   // Drives one cycle of access/finish on the selected IF (the other IF's
   // strobes are cleared, ifSel<0 clears both); queues the access when it
   // is expected to be accepted by the memory
   task automatic applyStimulus(input int ifSel, input logic ena, input logic rw,
                                input logic [18:0] addr, input logic [31:0] data,
                                input logic finish, input logic expAccept);
      memTxn_t txn;
      if0Ena = 1'b0; if0Finish = 1'b0;
      if1Ena = 1'b0; if1Finish = 1'b0;
      if (ifSel == 0) begin
         if0Ena = ena; if0Rw = rw; if0Addr = addr; if0DataIn = data; if0Finish = finish;
      end else if (ifSel == 1) begin
         if1Ena = ena; if1Rw = rw; if1Addr = addr; if1DataIn = data; if1Finish = finish;
      end
      if (expAccept) begin
         txn.rw = rw; txn.addr = addr; txn.data = data;
         memQ.push_back(txn);
      end
   endtask

   // Drives a memory read return for one cycle; queues it when it should be
   // routed to IF ifSel
   task automatic driveReturn(input logic [31:0] data, input logic expRoute, input logic ifSel);
      memValid  = 1'b1;
      memDataIn = data;
      if (expRoute) retQ.push_back({ifSel, data});
   endtask

   task automatic resetDut();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   // Scoreboard monitor: memory-port accepts and IF read returns
   always @(negedge clock) begin
      memTxn_t expTxn;
      logic [32:0] expRet;
      logic [31:0] gotData;
      if (!reset && memEna && !memBusy) begin
         if (memQ.size() == 0) begin
            checkOutput("memUnexpected", {12'h0, memRw, memAddr, memDataOut}, 64'h0);
         end else begin
            expTxn = memQ.pop_front();
            checkOutput("memTxn", {12'h0, memRw, memAddr, memDataOut}, {12'h0, expTxn});
         end
      end
      if (if0Valid || if1Valid) begin
         gotData = if1Valid ? if1DataOut : if0DataOut;
         if (retQ.size() == 0) begin
            checkOutput("retUnexpected", {30'h0, if1Valid, if0Valid, gotData}, 64'h0);
         end else begin
            expRet = retQ.pop_front();
            checkOutput("retRoute", {30'h0, if1Valid, if0Valid, gotData},
                        {30'h0, expRet[32], ~expRet[32], expRet[31:0]});
         end
      end
   end

   // Absolute safety net against a hung run
   initial begin
      #200000;
      $display("[TB] FAIL globalTimeout: got stuck expected finish");
      $fatal(1, "[TB] run exceeded time limit");
   end

   initial begin
      int seenAt;
      logic sawTimeout;

      // ---- reset values ----
      step();
      sample();
      checkOutput("rstFlags", {56'h0, if0Ack, if1Ack, if0Busy, if1Busy, if0Valid, if1Valid, memEna, timeoutPulse},
                  {56'h0, 8'b0011_0000});
      checkOutput("rstMemAddr", {45'h0, memAddr}, 64'h0);
      checkOutput("rstData", {memDataOut, if0DataOut}, 64'h0);
      checkOutput("rstData1", {32'h0, if1DataOut}, 64'h0);
      step();
      reset = 1'b0;

      // ---- test 1: IF0 alone, two writes, finish ----
      $display("[TB] test 1: single requester writes");
      step(); if0Req = 1'b1;
      sample(); checkOutput("t1AckEarly", if0Ack, 0);
      step(); applyStimulus(0, 1, 1, 19'h00010, 32'hA5A5_0001, 0, 1);
      sample();
      checkOutput("t1Ack0", {if1Ack, if0Ack}, 2'b01);
      checkOutput("t1Busy", {if1Busy, if0Busy}, 2'b10);
      step(); if0Req = 1'b0; applyStimulus(0, 1, 1, 19'h00011, 32'hA5A5_0002, 0, 1);
      sample(); checkOutput("t1AckPulse", if0Ack, 0);
      step(); applyStimulus(0, 0, 0, '0, '0, 1, 0);
      sample(); checkOutput("t1Busy1Fin", if1Busy, 1);
      step(); applyStimulus(-1, 0, 0, '0, '0, 0, 0);
      sample(); checkOutput("t1Idle", {if0Busy, if1Busy, memEna}, 3'b110);

      // ---- test 2: tie after reset, then round-robin tie ----
      $display("[TB] test 2: round-robin ties");
      resetDut();
      step(); if0Req = 1'b1; if1Req = 1'b1;
      sample(); checkOutput("t2NoAckYet", {if1Ack, if0Ack}, 2'b00);
      step();
      sample(); checkOutput("t2Tie1", {if1Ack, if0Ack}, 2'b01);
      step(); if0Req = 1'b0; applyStimulus(0, 0, 0, '0, '0, 1, 0);
      sample(); checkOutput("t2Waiting", {if1Ack, if1Busy}, 2'b01);
      step(); applyStimulus(-1, 0, 0, '0, '0, 0, 0); if0Req = 1'b1;
      sample(); checkOutput("t2GapCycle", {if1Ack, if0Ack}, 2'b00);
      step();
      sample(); checkOutput("t2Tie2", {if1Ack, if0Ack}, 2'b10);

      // ---- test 3: IF1 reads, finish into drain, IF0 waits ----
      $display("[TB] test 3: drain before hand-over");
      for (int i = 0; i < 3; i++) begin
         step(); if1Req = 1'b0;
         applyStimulus(1, 1, 0, 19'(32'h200 + i), 32'h0, 0, 1);
      end
      step(); applyStimulus(1, 0, 0, '0, '0, 1, 0);
      sample(); checkOutput("t3Busy0", if0Busy, 1);
      step(); applyStimulus(1, 1, 0, 19'h2FF, 32'h0, 0, 0);
      sample(); checkOutput("t3DrainGate", {memEna, if0Busy, if1Busy, if0Ack}, 4'b0110);
      for (int i = 0; i < 3; i++) begin
         step(); applyStimulus(-1, 0, 0, '0, '0, 0, 0);
         sample(); checkOutput("t3DrainNoAck", {if0Ack, if1Busy}, 2'b01);
      end
      for (int i = 0; i < 3; i++) begin
         step(); driveReturn(32'hD000_0000 + i, 1, 1'b1);
         sample(); checkOutput("t3RetNoAck", if0Ack, 0);
      end
      step(); memValid = 1'b0;
      sample(); checkOutput("t3IdleGap", {if0Ack, if0Busy}, 2'b01);
      step();
      sample(); checkOutput("t3Ack0", {if1Ack, if0Ack}, 2'b01);

      // ---- test 4: fill the outstanding tracker ----
      $display("[TB] test 4: outstanding limit");
      step(); if0Req = 1'b0; memBusy = 1'b1;
      applyStimulus(0, 1, 0, 19'h2FF, 32'h0, 0, 0);
      sample(); checkOutput("t4MemBusy", {memEna, if0Busy}, 2'b11);
      for (int i = 0; i < 15; i++) begin
         step(); memBusy = 1'b0;
         applyStimulus(0, 1, 0, 19'(32'h300 + i), 32'h0, 0, 1);
         sample();
         if (i == 0) checkOutput("t4NotBusy", if0Busy, 0);
      end
      step(); applyStimulus(0, 1, 0, 19'h30F, 32'h0, 0, 0);
      sample(); checkOutput("t4Full", {memEna, if0Busy}, 2'b01);
      step(); driveReturn(32'h0000_1234, 1, 1'b0);
      sample(); checkOutput("t4StillFull", memEna, 0);
      step(); memValid = 1'b0; applyStimulus(0, 1, 0, 19'h30F, 32'h0, 0, 1);
      sample(); checkOutput("t4Accepted", {memEna, if0Busy}, 2'b10);
      step(); applyStimulus(-1, 0, 0, '0, '0, 0, 0);

      // ---- test 5: reset with reads outstanding ----
      $display("[TB] test 5: reset mid-read");
      resetDut();
      step(); if0Req = 1'b1;
      step();
      sample(); checkOutput("t5Ack0", if0Ack, 1);
      step(); if0Req = 1'b0; applyStimulus(0, 1, 0, 19'h400, 32'h0, 0, 1);
      step(); applyStimulus(0, 1, 0, 19'h401, 32'h0, 0, 1);
      step(); applyStimulus(-1, 0, 0, '0, '0, 0, 0); reset = 1'b1;
      step(); reset = 1'b0; driveReturn(32'h0000_0BAD, 0, 1'b0);
      sample();
      checkOutput("t5Idle", {if0Busy, if1Busy, memEna}, 3'b110);
      checkOutput("t5LateRet", {30'h0, if1Valid, if0Valid, if0DataOut}, 64'h0);
      step(); memValid = 1'b0; if0Req = 1'b1;
      step();
      sample(); checkOutput("t5Regrant", if0Ack, 1);
      step(); if0Req = 1'b0; applyStimulus(0, 0, 0, '0, '0, 1, 0);
      step(); applyStimulus(-1, 0, 0, '0, '0, 0, 0); if1Req = 1'b1;
      sample(); checkOutput("t5GapCycle", if1Ack, 0);
      step();
      sample(); checkOutput("t5CountClear", if1Ack, 1);

      // ---- test 6: watchdog ----
      step(); if1Req = 1'b0;
`ifdef GCI_STD_DISPLAY_VRAM_ARB_TIMEOUT_EN
      $display("[TB] test 6: watchdog enabled");
      seenAt = 0;
      for (int k = 2; k <= 40; k++) begin
         step();
         sample();
         if (timeoutPulse && seenAt == 0) seenAt = k;
      end
      checkOutput("t6TimeoutAt", 64'(seenAt), 64'd16);
      checkOutput("t6Released", if1Busy, 1);
`else
      $display("[TB] test 6: watchdog disabled");
      sawTimeout = 1'b0;
      seenAt = 0;
      for (int k = 0; k < 100; k++) begin
         step();
         sample();
         if (timeoutPulse) sawTimeout = 1'b1;
      end
      checkOutput("t6StillOwner", if1Busy, 0);
      checkOutput("t6NoTimeout", sawTimeout, 0);
`endif

      step();
      checkOutput("memQEmpty", 64'(memQ.size()), 64'd0);
      checkOutput("retQEmpty", 64'(retQ.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
